reg_file_2r1w: RTL

Sixteen-entry, 16-bit register file built on the per-bit storage cell behaviour: one synchronous write port, two read ports, write-through bypass, hardwired-zero register 0. It adds a per-register pending-load scoreboard so the decode stage can stall on operands whose load has not yet written back. It sits between the decode stage (read addresses, scoreboard set) and the writeback stage (write port, scoreboard clear).

---
 rtl/reg_file_2r1w.sv | 81 ++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 16x16 register file, two read ports, one write port, pending-load scoreboard
// Register 0 reads as zero; same-cycle writes bypass to both read ports and clear Stall.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     SrcReg1,
  input  logic [ADDR_W-1:0]     SrcReg2,
  output logic [DATA_WIDTH-1:0] SrcData1,
  output logic [DATA_WIDTH-1:0] SrcData2,
  input  logic [ADDR_W-1:0]     DstReg,
  input  logic [DATA_WIDTH-1:0] DstData,
  input  logic                  WriteReg,
  input  logic                  SetPend,
  input  logic [ADDR_W-1:0]     PendReg,
  output logic                  Stall,
  output logic [NUM_REGS-1:0]   PendVec
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q;
  logic [NUM_REGS-1:0]   pend_d;
  logic                  wr_en;
  logic                  set_en;
  logic                  hit1;
  logic                  hit2;

  // Gating with rst_n suppresses bypass and scoreboard clear while in reset.
  assign wr_en  = rst_n && WriteReg && (DstReg != '0);
  assign set_en = SetPend && (PendReg != '0);
  assign hit1   = wr_en && (SrcReg1 == DstReg);
  assign hit2   = wr_en && (SrcReg2 == DstReg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[DstReg] <= DstData;
    end
  end

  // Set is applied after clear so a new load issued as the old one retires stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[DstReg] = 1'b0;
    end
    if (set_en) begin
      pend_d[PendReg] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    SrcData1 = '0;
    SrcData2 = '0;
    if (rst_n && (SrcReg1 != '0)) begin
      SrcData1 = hit1 ? DstData : regs_q[SrcReg1];
    end
    if (rst_n && (SrcReg2 != '0)) begin
      SrcData2 = hit2 ? DstData : regs_q[SrcReg2];
    end
  end

  assign Stall   = rst_n && ((pend_q[SrcReg1] && !hit1) || (pend_q[SrcReg2] && !hit2));
  assign PendVec = pend_q;

endmodule
